// File: rtl/uart_regfile.sv
// Register bank fed by the UART receiver: turns the ready level into single write
// events, stores bytes in a flop bank, and emits per-register strobes and channel triggers.
module uart_regfile #(
    parameter int         NUM_REGS    = 16,
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter logic [1:0] TRIG_SLOT   = 2'd3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     uart_addr,
    input  logic [7:0]            uart_data,
    input  logic                  uart_ready,
    output logic [NUM_REGS*8-1:0] reg_bus,
    output logic [NUM_REGS-1:0]   wr_strobe,
    output logic [3:0]            trig,
    output logic [7:0]            wr_count
);

    logic       ready_d_reg;
    logic       wr_evt;
    logic       trig_hit;
    logic [7:0] count_reg;
    logic [7:0] count_next;

    // Resetting ready_d high stops a ready level that is already up from
    // looking like a fresh edge once reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_d_reg <= 1'b1;
        end else begin
            ready_d_reg <= uart_ready;
        end
    end

    assign wr_evt     = uart_ready & ~ready_d_reg;
    assign trig_hit   = wr_evt && (uart_addr[1:0] == TRIG_SLOT);
    assign count_next = count_reg + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 8'd0;
        end else if (wr_evt) begin
            count_reg <= count_next;
        end
    end

    assign wr_count = count_reg;

    // One storage byte and strobe flop per register, each decoding its own address.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] value_reg;
            logic       strobe_reg;
            logic       hit;

            assign hit = wr_evt && (uart_addr == ADDR_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    value_reg  <= RESET_VALUE;
                    strobe_reg <= 1'b0;
                end else begin
                    strobe_reg <= hit;
                    if (hit) begin
                        value_reg <= uart_data;
                    end
                end
            end

            assign reg_bus[gi*8 +: 8] = value_reg;
            assign wr_strobe[gi]      = strobe_reg;
        end
    endgenerate

    // Channel n owns addresses 4n..4n+3; the TRIG_SLOT register of that group fires it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_trig
            logic trig_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    trig_reg <= 1'b0;
                end else begin
                    trig_reg <= trig_hit && (uart_addr[3:2] == 2'(gi));
                end
            end

            assign trig[gi] = trig_reg;
        end
    endgenerate

endmodule

// File: tb/tb_uart_regfile.sv
// Directed bench for uart_regfile: reset, edge-detected writes, held-ready
// suppression, trigger decode, counter wrap and reset/ready interaction.
module tb_uart_regfile;

    logic         clk;
    logic         rst;
    logic [3:0]   uart_addr;
    logic [7:0]   uart_data;
    logic         uart_ready;
    logic [127:0] reg_bus;
    logic [15:0]  wr_strobe;
    logic [3:0]   trig;
    logic [7:0]   wr_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] exp_bank [16];
    logic [7:0] exp_count;

    uart_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .uart_addr  (uart_addr),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .reg_bus    (reg_bus),
        .wr_strobe  (wr_strobe),
        .trig       (trig),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model_bus();
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[i*8 +: 8] = exp_bank[i];
        return b;
    endfunction

    // Low-then-high ready pulse with new addr/data; returns after the write edge.
    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        uart_ready = 1'b0;
        tick();
        uart_addr  = a;
        uart_data  = d;
        uart_ready = 1'b1;
        tick();
        exp_bank[a] = d;
        exp_count   = exp_count + 8'd1;
    endtask

    initial begin
        int strobe_seen;
        rst        = 1'b1;
        uart_addr  = 4'h0;
        uart_data  = 8'h00;
        uart_ready = 1'b0;
        for (int i = 0; i < 16; i++) exp_bank[i] = 8'h00;
        exp_count = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("reset_bus",    reg_bus,   128'h0);
        check_eq("reset_strobe", wr_strobe, 128'h0);
        check_eq("reset_trig",   trig,      128'h0);
        check_eq("reset_count",  wr_count,  128'h0);

        // First write: addr 5, data A7
        uart_addr  = 4'h5;
        uart_data  = 8'hA7;
        uart_ready = 1'b1;
        tick();
        check_eq("w5_reg",    reg_bus[47:40], 128'hA7);
        check_eq("w5_strobe", wr_strobe,      128'h0020);
        check_eq("w5_trig",   trig,           128'h0);
        check_eq("w5_count",  wr_count,       128'd1);
        tick();
        check_eq("w5_strobe_clear", wr_strobe, 128'h0);

        // Ready held high while addr/data change: nothing more may be written
        uart_addr   = 4'h9;
        uart_data   = 8'h3C;
        strobe_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wr_strobe != 16'h0) strobe_seen++;
        end
        check_eq("held_strobes", 128'(strobe_seen), 128'd0);
        check_eq("held_reg9",    reg_bus[79:72],    128'h00);
        check_eq("held_count",   wr_count,          128'd1);

        // Write addr B -> trigger channel 2
        uart_ready = 1'b0;
        tick();
        uart_addr  = 4'hB;
        uart_data  = 8'h55;
        uart_ready = 1'b1;
        tick();
        check_eq("wB_reg",    reg_bus[95:88], 128'h55);
        check_eq("wB_strobe", wr_strobe,      128'h0800);
        check_eq("wB_trig",   trig,           128'h4);
        check_eq("wB_count",  wr_count,       128'd2);
        tick();
        check_eq("wB_strobe_clear", wr_strobe, 128'h0);
        check_eq("wB_trig_clear",   trig,      128'h0);

        // 256 writes to rotating addresses; counter starts at 2
        exp_bank[5]  = 8'hA7;
        exp_bank[11] = 8'h55;
        exp_count    = 8'd2;
        for (int i = 0; i < 256; i++) begin
            do_write(4'(i), 8'(i * 37 + 5));
            if (i == 252) check_eq("count_255", wr_count, 128'd255);
            if (i == 253) check_eq("count_wrap", wr_count, 128'd0);
        end
        check_eq("bulk_count", wr_count,  128'(exp_count));
        check_eq("bulk_bank",  reg_bus,   model_bus());

        // Reset with ready already high: no write afterwards
        uart_addr  = 4'h6;
        uart_data  = 8'hEE;
        uart_ready = 1'b1;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_eq("rsthi_count",  wr_count,  128'd0);
        check_eq("rsthi_bus",    reg_bus,   128'h0);
        check_eq("rsthi_strobe", wr_strobe, 128'h0);

        // Normal write after low-then-high
        uart_ready = 1'b0;
        tick();
        uart_addr  = 4'h3;
        uart_data  = 8'h9E;
        uart_ready = 1'b1;
        tick();
        check_eq("w3_reg",    reg_bus[31:24], 128'h9E);
        check_eq("w3_strobe", wr_strobe,      128'h0008);
        check_eq("w3_trig",   trig,           128'h1);
        check_eq("w3_count",  wr_count,       128'd1);

        // Reset coincident with a write event: the write is lost
        uart_ready = 1'b0;
        tick();
        uart_addr  = 4'h7;
        uart_data  = 8'h11;
        uart_ready = 1'b1;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_eq("rstevt_reg7",   reg_bus[63:56], 128'h00);
        check_eq("rstevt_count",  wr_count,       128'd0);
        check_eq("rstevt_strobe", wr_strobe,      128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
